// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the iterative ALU.
package alu_pkg;

   localparam logic [2:0] OP_FWD = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRA = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_MUL   = 2'b10
   } state_e;

   function automatic logic is_shift(input logic [2:0] op);
      return (op == OP_SLL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_iter_comb.sv
// Single-cycle ALU ops (FWD/ADD/AND/OR/SUB) with carry / not-borrow.
module alu_iter_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   logic [WIDTH:0] sum_s;
   logic [WIDTH:0] diff_s;

   // Borrow of the extended subtraction lands in the top bit, so CARRY is its inverse.
   always_comb begin
      sum_s  = {1'b0, a} + {1'b0, b};
      diff_s = {1'b0, a} - {1'b0, b};
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_FWD: result = b;
         OP_ADD: begin
            result = sum_s[WIDTH-1:0];
            carry  = sum_s[WIDTH];
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_SUB: begin
            result = diff_s[WIDTH-1:0];
            carry  = ~diff_s[WIDTH];
         end
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/arith, bit-serial shifts and shift-add multiply.
// Define ALU_ITER_MUL_EN to build the multiplier; otherwise opcode 111 yields zero in one cycle.
module alu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [2:0]       SELECT,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   output logic [WIDTH-1:0] RESULT,
   output logic             CARRY,
   output logic             ZERO,
   output logic             BUSY,
   output logic             DONE
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;

   state_e           state_r, state_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic [2:0]       op_r, op_s;
   logic [WIDTH-1:0] work_r, work_s;
   logic [WIDTH-1:0] result_r, result_s;
   logic             carry_r, carry_s;
   logic             zero_r, zero_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;

   logic [WIDTH-1:0] comb_res_s;
   logic             comb_carry_s;
   logic [WIDTH-1:0] fast_res_s;
   logic [WIDTH-1:0] shift1_s;
   logic [SHW-1:0]   amt_s;

`ifdef ALU_ITER_MUL_EN
   logic [WIDTH-1:0] mcand_r, mcand_s;
   logic [WIDTH-1:0] acc_r, acc_s;
   logic [WIDTH-1:0] acc_sum_s;
`endif

   alu_iter_comb #(.WIDTH(WIDTH)) u_comb (
      .op     (SELECT),
      .a      (DATA1),
      .b      (DATA2),
      .result (comb_res_s),
      .carry  (comb_carry_s)
   );

   // Shift by zero passes DATA1 through; a compiled-out multiply returns zero.
   always_comb begin
      amt_s    = DATA2[SHW-1:0];
      shift1_s = (op_r == OP_SLL) ? {work_r[WIDTH-2:0], 1'b0}
                                  : {work_r[WIDTH-1], work_r[WIDTH-1:1]};
      if (is_shift(SELECT)) begin
         fast_res_s = DATA1;
      end else if (SELECT == OP_MUL) begin
         fast_res_s = '0;
      end else begin
         fast_res_s = comb_res_s;
      end
`ifdef ALU_ITER_MUL_EN
      acc_sum_s = acc_r + (work_r[0] ? mcand_r : {WIDTH{1'b0}});
`endif
   end

   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      op_s     = op_r;
      work_s   = work_r;
      result_s = result_r;
      carry_s  = carry_r;
      zero_s   = zero_r;
      busy_s   = busy_r;
      done_s   = 1'b0;
`ifdef ALU_ITER_MUL_EN
      mcand_s  = mcand_r;
      acc_s    = acc_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (START) begin
               op_s   = SELECT;
               work_s = DATA1;
               if (is_shift(SELECT) && (amt_s != '0)) begin
                  state_s = ST_SHIFT;
                  cnt_s   = {1'b0, amt_s};
                  busy_s  = 1'b1;
`ifdef ALU_ITER_MUL_EN
               end else if (SELECT == OP_MUL) begin
                  state_s = ST_MUL;
                  cnt_s   = CW'(WIDTH);
                  busy_s  = 1'b1;
                  mcand_s = DATA1;
                  work_s  = DATA2;
                  acc_s   = '0;
`endif
               end else begin
                  result_s = fast_res_s;
                  carry_s  = comb_carry_s;
                  zero_s   = (fast_res_s == '0);
                  done_s   = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            work_s = shift1_s;
            cnt_s  = cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
               result_s = shift1_s;
               carry_s  = 1'b0;
               zero_s   = (shift1_s == '0);
               done_s   = 1'b1;
               busy_s   = 1'b0;
               state_s  = ST_IDLE;
            end else begin
               state_s = ST_SHIFT;
            end
         end
`ifdef ALU_ITER_MUL_EN
         // Radix-2 shift-add: work_r holds the multiplier, consumed LSB first.
         ST_MUL: begin
            acc_s   = acc_sum_s;
            mcand_s = {mcand_r[WIDTH-2:0], 1'b0};
            work_s  = {1'b0, work_r[WIDTH-1:1]};
            cnt_s   = cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
               result_s = acc_sum_s;
               carry_s  = 1'b0;
               zero_s   = (acc_sum_s == '0);
               done_s   = 1'b1;
               busy_s   = 1'b0;
               state_s  = ST_IDLE;
            end else begin
               state_s = ST_MUL;
            end
         end
`endif
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // Synchronous reset aborts any operation in flight and clears all outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r  <= ST_IDLE;
         cnt_r    <= '0;
         op_r     <= 3'b000;
         work_r   <= '0;
         result_r <= '0;
         carry_r  <= 1'b0;
         zero_r   <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
`ifdef ALU_ITER_MUL_EN
         mcand_r  <= '0;
         acc_r    <= '0;
`endif
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         op_r     <= op_s;
         work_r   <= work_s;
         result_r <= result_s;
         carry_r  <= carry_s;
         zero_r   <= zero_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
`ifdef ALU_ITER_MUL_EN
         mcand_r  <= mcand_s;
         acc_r    <= acc_s;
`endif
      end
   end

   assign RESULT = result_r;
   assign CARRY  = carry_r;
   assign ZERO   = zero_r;
   assign BUSY   = busy_r;
   assign DONE   = done_r;

endmodule

// File: tb/tb_alu_iter.sv
// Directed table plus corner sequences on an 8-bit alu_iter, random regression on a 16-bit one.
module tb_alu_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  sel;
   logic [7:0]  d1, d2;
   logic [7:0]  res;
   logic        carry, zero, busy, done;

   logic        s16;
   logic [2:0]  sel16;
   logic [15:0] a16, b16;
   logic [15:0] res16;
   logic        carry16, zero16, busy16, done16;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string      name;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       c;
      logic       z;
      int         lat;
   } vec_t;

   vec_t vecs[$];

   alu_iter #(.WIDTH(8)) dut (
      .CLK(clk), .RESET(rst), .START(start), .SELECT(sel), .DATA1(d1), .DATA2(d2),
      .RESULT(res), .CARRY(carry), .ZERO(zero), .BUSY(busy), .DONE(done)
   );

   alu_iter #(.WIDTH(16)) dut16 (
      .CLK(clk), .RESET(rst), .START(s16), .SELECT(sel16), .DATA1(a16), .DATA2(b16),
      .RESULT(res16), .CARRY(carry16), .ZERO(zero16), .BUSY(busy16), .DONE(done16)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Issue one request on the 8-bit DUT and check result, flags, latency and BUSY span.
   task automatic do_op(input vec_t v);
      int lat;
      int busy_cnt;
      @(negedge clk);
      start = 1'b1; sel = v.op; d1 = v.a; d2 = v.b;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      chk({v.name, " done"}, 32'(done), 32'd1);
      chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
      chk({v.name, " busy cycles"}, 32'(busy_cnt), 32'(v.lat - 1));
      chk({v.name, " busy in done"}, 32'(busy), 32'd0);
      chk({v.name, " result"}, 32'(res), 32'(v.res));
      chk({v.name, " carry"}, 32'(carry), 32'(v.c));
      chk({v.name, " zero"}, 32'(zero), 32'(v.z));
      @(negedge clk);
      chk({v.name, " done single pulse"}, 32'(done), 32'd0);
      chk({v.name, " result held"}, 32'(res), 32'(v.res));
   endtask

   // One random request on the 16-bit DUT against an operator-level reference.
   task automatic op16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] wide;
      logic [15:0] er;
      logic        ec;
      int          elat;
      int          first;
      int          pulses;
      logic [15:0] got_r;
      logic        got_c, got_z;
      ec = 1'b0;
      elat = 1;
      case (op)
         3'b000: er = b;
         3'b001: begin wide = {1'b0, a} + {1'b0, b}; er = wide[15:0]; ec = wide[16]; end
         3'b010: er = a & b;
         3'b011: er = a | b;
         3'b100: begin er = a - b; ec = (a >= b); end
         3'b101: begin er = a << b[3:0]; elat = (b[3:0] == 4'd0) ? 1 : int'(b[3:0]) + 1; end
         3'b110: begin er = 16'($signed(a) >>> b[3:0]); elat = (b[3:0] == 4'd0) ? 1 : int'(b[3:0]) + 1; end
         default: begin
`ifdef ALU_ITER_MUL_EN
            er = 16'(a * b); elat = 17;
`else
            er = 16'd0;
`endif
         end
      endcase
      @(negedge clk);
      s16 = 1'b1; sel16 = op; a16 = a; b16 = b;
      @(negedge clk);
      s16 = 1'b0;
      first = 0; pulses = 0; got_r = 16'd0; got_c = 1'b0; got_z = 1'b0;
      for (int cyc = 1; cyc <= elat + 3; cyc++) begin
         if (done16) begin
            pulses++;
            if (first == 0) begin
               first = cyc; got_r = res16; got_c = carry16; got_z = zero16;
            end
         end
         @(negedge clk);
      end
      chk($sformatf("r16 op%0d latency", op), 32'(first), 32'(elat));
      chk($sformatf("r16 op%0d done pulses", op), 32'(pulses), 32'd1);
      chk($sformatf("r16 op%0d result", op), 32'(got_r), 32'(er));
      chk($sformatf("r16 op%0d carry", op), 32'(got_c), 32'(ec));
      chk($sformatf("r16 op%0d zero", op), 32'(got_z), 32'(er == 16'd0));
   endtask

   initial begin
      int lat;
      int pulses;
      rst = 1'b1; start = 1'b0; sel = 3'b000; d1 = 8'h00; d2 = 8'h00;
      s16 = 1'b0; sel16 = 3'b000; a16 = 16'h0000; b16 = 16'h0000;

      vecs.push_back('{"add ff+01", 3'b001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1});
      vecs.push_back('{"sub 05-07", 3'b100, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1});
      vecs.push_back('{"sub 07-07", 3'b100, 8'h07, 8'h07, 8'h00, 1'b1, 1'b1, 1});
      vecs.push_back('{"sra 90>>3", 3'b110, 8'h90, 8'h03, 8'hF2, 1'b0, 1'b0, 4});
      vecs.push_back('{"sll 81<<0", 3'b101, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1});
      vecs.push_back('{"fwd aa", 3'b000, 8'h12, 8'hAA, 8'hAA, 1'b0, 1'b0, 1});
      vecs.push_back('{"and f0&3c", 3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1});
      vecs.push_back('{"or f0|0f", 3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1});
      vecs.push_back('{"add 7f+01", 3'b001, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1});
      vecs.push_back('{"sll 01<<7", 3'b101, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 8});
      vecs.push_back('{"sll 81<<0b", 3'b101, 8'h81, 8'h0B, 8'h08, 1'b0, 1'b0, 4});
      vecs.push_back('{"sra 40>>2", 3'b110, 8'h40, 8'h02, 8'h10, 1'b0, 1'b0, 3});
      vecs.push_back('{"sra 80>>7", 3'b110, 8'h80, 8'h07, 8'hFF, 1'b0, 1'b0, 8});
`ifdef ALU_ITER_MUL_EN
      vecs.push_back('{"mul 13x11", 3'b111, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 9});
      vecs.push_back('{"mul 10x10", 3'b111, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 9});
      vecs.push_back('{"mul ffxff", 3'b111, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 9});
`else
      vecs.push_back('{"op111 off", 3'b111, 8'd13, 8'd11, 8'h00, 1'b0, 1'b1, 1});
`endif

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset result", 32'(res), 32'd0);
      chk("reset carry", 32'(carry), 32'd0);
      chk("reset zero", 32'(zero), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);

      for (int i = 0; i < vecs.size(); i++) do_op(vecs[i]);

      // Reset mid-multiply: no DONE, outputs cleared.
      @(negedge clk);
      start = 1'b1; sel = 3'b111; d1 = 8'd12; d2 = 8'd13;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst mid busy", 32'(busy), 32'd0);
      chk("rst mid result", 32'(res), 32'd0);
      chk("rst mid done", 32'(done), 32'd0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) pulses++;
         @(negedge clk);
      end
      chk("rst mid no done", 32'(pulses), 32'd0);
      chk("rst mid result stays", 32'(res), 32'd0);
      do_op('{"post-rst add", 3'b001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1});

      // START pulsed while an SLL is busy must be ignored.
      @(negedge clk);
      start = 1'b1; sel = 3'b101; d1 = 8'h03; d2 = 8'h05;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; sel = 3'b000; d1 = 8'h00; d2 = 8'hAA;
      @(negedge clk);
      start = 1'b0;
      lat = 3;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("ignored start latency", 32'(lat), 32'd6);
      chk("ignored start result", 32'(res), 32'h60);
      @(negedge clk);
      chk("ignored start no 2nd done", 32'(done), 32'd0);
      chk("ignored start result held", 32'(res), 32'h60);

      // Back-to-back: START held in the DONE cycle is accepted.
      @(negedge clk);
      start = 1'b1; sel = 3'b101; d1 = 8'h01; d2 = 8'h02;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("b2b sll latency", 32'(lat), 32'd3);
      chk("b2b sll result", 32'(res), 32'h04);
      start = 1'b1; sel = 3'b011; d1 = 8'hF0; d2 = 8'h0F;
      @(negedge clk);
      start = 1'b0;
      chk("b2b or done", 32'(done), 32'd1);
      chk("b2b or result", 32'(res), 32'hFF);
      chk("b2b or busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("b2b or done pulse", 32'(done), 32'd0);

      // Random regression on the 16-bit instance.
      for (int i = 0; i < 40; i++) begin
         op16(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      end
      op16(3'b111, 16'h0100, 16'h0100);
      op16(3'b110, 16'h8001, 16'h000F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
